// File: rtl/bdos_pkg.sv
// Shared definitions for the CP/M BDOS console responder.
// The RX state exists only when BDOS_CONIN_EN is defined.
package bdos_pkg;

  localparam logic [7:0] BDOS_CONIN  = 8'd1;
  localparam logic [7:0] BDOS_CONOUT = 8'd2;
  localparam logic [7:0] BDOS_PRINT  = 8'd9;
  localparam logic [7:0] BDOS_TERM   = 8'h24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
`ifdef BDOS_CONIN_EN
    ST_RX,
`endif
    ST_DONE
  } state_e;

endpackage

// File: rtl/bdos_console.sv
// BDOS console responder: serves function 2 (print char) and function 9
// (print '$'-terminated string) while stalling the CPU through busy.
// Optional macro BDOS_CONIN_EN adds function 1 (console input with echo)
// and the rx_*/a_* ports.
module bdos_console
  import bdos_pkg::*;
#(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap,
  input  logic [7:0]  func,
  input  logic [15:0] arg,
  output logic        busy,
  output logic        done,
  output logic        bad_func,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef BDOS_CONIN_EN
  ,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  a_out,
  output logic        a_we
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    func_q, func_d;
  logic [15:0]   ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          bad_q, bad_d;
`ifdef BDOS_CONIN_EN
  logic [7:0]    a_q, a_d;
  logic          a_we_q, a_we_d;
`endif

  // State and datapath registers; reset puts everything back to IDLE at once.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      func_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      bad_q   <= 1'b0;
`ifdef BDOS_CONIN_EN
      a_q     <= '0;
      a_we_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      bad_q   <= bad_d;
`ifdef BDOS_CONIN_EN
      a_q     <= a_d;
      a_we_q  <= a_we_d;
`endif
    end
  end

  // Next-state and datapath update for the call sequencer.
  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    bad_d   = bad_q;
`ifdef BDOS_CONIN_EN
    a_d     = a_q;
    a_we_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (trap) begin
          func_d = func;
          cnt_d  = '0;
          bad_d  = 1'b0;
          if (func == BDOS_CONOUT) begin
            byte_d  = arg[7:0];
            state_d = ST_SEND;
          end else if (func == BDOS_PRINT) begin
            ptr_d   = arg;
            state_d = ST_FETCH;
`ifdef BDOS_CONIN_EN
          end else if (func == BDOS_CONIN) begin
            state_d = ST_RX;
`endif
          end else begin
            bad_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // The read issued in FETCH lands here; '$' ends the string unsent.
        if (mem_data == BDOS_TERM) begin
          state_d = ST_DONE;
        end else if (cnt_q == MAX_CNT) begin
          bad_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          byte_d  = mem_data;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (func_q == BDOS_PRINT) begin
            ptr_d   = ptr_q + 16'd1;
            cnt_d   = cnt_q + CW'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
`ifdef BDOS_CONIN_EN
      ST_RX: begin
        if (rx_valid) begin
          byte_d  = rx_data;
          a_d     = rx_data;
          a_we_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state and latched data.
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign bad_func = (state_q == ST_DONE) && bad_q;
  assign mem_rd   = (state_q == ST_FETCH);
  assign mem_addr = ptr_q;
  assign tx_valid = (state_q == ST_SEND);
  assign tx_data  = byte_q;
`ifdef BDOS_CONIN_EN
  assign rx_ready = (state_q == ST_RX);
  assign a_out    = a_q;
  assign a_we     = a_we_q;
`endif

endmodule

// File: tb/tb_bdos_console.sv
// Scoreboard bench for bdos_console: a reference model derives the expected
// tx bytes, RAM reads and done/bad outcomes from RAM contents; a negedge
// monitor pops and compares whenever the DUT presents them.
module tb_bdos_console;
  import bdos_pkg::*;

  localparam int MAX_LEN = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap = 1'b0;
  logic [7:0]  func = '0;
  logic [15:0] arg = '0;
  logic        busy, done, bad_func, mem_rd, tx_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
`ifdef BDOS_CONIN_EN
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, a_we;
  logic [7:0]  a_out;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0]  ram [65536];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_rd[$];
  int          exp_done[$];
  logic [7:0]  exp_a[$];

  bit          ready_rand = 1'b0;
  bit          check_lat  = 1'b1;
  bit          hold_pending = 1'b0;
  logic [7:0]  hold_data;
  logic [8:0]  e_tx;
  logic [16:0] e_rd;
  int          e_done;
  logic [8:0]  e_a;

  bdos_console #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .trap(trap), .func(func), .arg(arg),
    .busy(busy), .done(done), .bad_func(bad_func),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef BDOS_CONIN_EN
    , .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .a_out(a_out), .a_we(a_we)
`endif
  );

  always #5 clk = ~clk;

  // RAM with one-cycle read latency.
  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

  // Random back-pressure on the console sink.
  always @(posedge clk) begin
    #1;
    if (ready_rand) tx_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT event against the head of its queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (tx_valid) begin
        if (hold_pending) check("tx_stable", tx_data, hold_data);
        if (tx_ready) begin
          e_tx = (exp_tx.size() != 0) ? {1'b0, exp_tx.pop_front()} : 9'h100;
          check("tx_byte", {1'b0, tx_data}, e_tx);
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          hold_data    = tx_data;
        end
      end else begin
        hold_pending = 1'b0;
      end
      if (mem_rd) begin
        e_rd = (exp_rd.size() != 0) ? {1'b0, exp_rd.pop_front()} : 17'h10000;
        check("rd_addr", {1'b0, mem_addr}, e_rd);
      end
      if (done) begin
        e_done = (exp_done.size() != 0) ? exp_done.pop_front() : 2;
        check("done_bad", bad_func, e_done);
      end
      if (bad_func) check("bad_with_done", done, 1);
`ifdef BDOS_CONIN_EN
      if (a_we) begin
        e_a = (exp_a.size() != 0) ? {1'b0, exp_a.pop_front()} : 9'h100;
        check("a_out", {1'b0, a_out}, e_a);
      end
`endif
    end
  end

  // Reference model: what a call should produce, from RAM and the BDOS rules.
  task automatic model(input logic [7:0] f, input logic [15:0] a,
                       input logic [7:0] rxb, output int lat);
    logic [15:0] p;
    int i;
    if (f == 8'd2) begin
      exp_tx.push_back(a[7:0]);
      exp_done.push_back(0);
      lat = 2;
    end else if (f == 8'd9) begin
      p = a;
      i = 0;
      forever begin
        exp_rd.push_back(p);
        if (ram[p] == 8'h24) begin
          exp_done.push_back(0);
          break;
        end
        if (i == MAX_LEN) begin
          exp_done.push_back(1);
          break;
        end
        exp_tx.push_back(ram[p]);
        p = p + 16'd1;
        i++;
      end
      lat = 3 * i + 3;
`ifdef BDOS_CONIN_EN
    end else if (f == 8'd1) begin
      exp_a.push_back(rxb);
      exp_tx.push_back(rxb);
      exp_done.push_back(0);
      lat = -1;
`endif
    end else begin
      exp_done.push_back(1);
      lat = 1;
    end
  endtask

  task automatic call(input logic [7:0] f, input logic [15:0] a, input logic [7:0] rxb);
    int lat;
    int cyc;
    model(f, a, rxb, lat);
    @(posedge clk); #1;
    func = f;
    arg  = a;
    trap = 1'b1;
    @(posedge clk); #1;
    trap = 1'b0;
    func = 8'($urandom);
    arg  = 16'($urandom);
    check("busy_after_trap", busy, 1);
    cyc = 1;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (trap) trap = 1'b0;
      // A stray trap while busy must be ignored.
      if (cyc == 2) trap = 1'b1;
`ifdef BDOS_CONIN_EN
      if (f == 8'd1) begin
        if (rx_valid && !rx_ready) rx_valid = 1'b0;
        if (cyc == 3) begin
          rx_data  = rxb;
          rx_valid = 1'b1;
        end
      end
`endif
    end
    trap = 1'b0;
    check("done_seen", done, 1);
    if (lat >= 0 && !ready_rand && check_lat) check("latency", cyc, lat);
    @(posedge clk); #1;
    check("idle_after_done", busy, 0);
    check("queues_drained", exp_tx.size() + exp_rd.size() + exp_done.size() + exp_a.size(), 0);
  endtask

  task automatic put_str(input logic [15:0] a, input string s);
    for (int i = 0; i < s.len(); i++) ram[a + 16'(i)] = s[i];
  endtask

  initial begin
    logic [7:0]  f;
    logic [15:0] a;
    int          len;
    logic [7:0]  b;
    int          w;

    // Reset state.
    #12;
    check("rst_ctrl", {busy, done, bad_func, mem_rd, tx_valid}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_txdata", tx_data, 0);
`ifdef BDOS_CONIN_EN
    check("rst_conin", {a_out, a_we, rx_ready}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Print char.
    call(8'd2, 16'h0041, 8'h00);

    // Print string.
    put_str(16'h0200, "HI$");
    call(8'd9, 16'h0200, 8'h00);

    // Same string, first byte stalled for 10 cycles.
    tx_ready  = 1'b0;
    check_lat = 1'b0;
    fork
      call(8'd9, 16'h0200, 8'h00);
      begin
        w = 0;
        while (!tx_valid && w < 50) begin
          @(posedge clk); #1;
          w++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, 8'h48);
        tx_ready = 1'b1;
      end
    join
    check_lat = 1'b1;

    // Pointer wraps 0xFFFF -> 0x0000.
    put_str(16'hFFFE, "AB");
    ram[16'h0000] = 8'h24;
    call(8'd9, 16'hFFFE, 8'h00);

    // Unsupported function.
    call(8'd7, 16'h1234, 8'h00);

    // Console input (bad_func when the feature is absent).
    call(8'd1, 16'h0000, 8'h7A);

    // String of exactly MAX_LEN characters, then one that never terminates.
    for (int i = 0; i < MAX_LEN; i++) ram[16'h3000 + 16'(i)] = 8'h61 + 8'(i);
    ram[16'h3000 + 16'(MAX_LEN)] = 8'h24;
    call(8'd9, 16'h3000, 8'h00);
    for (int i = 0; i < MAX_LEN + 2; i++) ram[16'h4000 + 16'(i)] = 8'h30 + 8'(i);
    call(8'd9, 16'h4000, 8'h00);

    // Reset during the second byte of "HI$".
    exp_rd.push_back(16'h0200);
    exp_tx.push_back(8'h48);
    exp_rd.push_back(16'h0201);
    @(posedge clk); #1;
    func = 8'd9;
    arg  = 16'h0200;
    trap = 1'b1;
    @(posedge clk); #1;
    trap = 1'b0;
    w = 0;
    while (!(tx_valid && tx_data == 8'h49) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    tx_ready = 1'b0;
    check("second_byte_seen", {tx_valid, tx_data}, {1'b1, 8'h49});
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, bad_func, mem_rd, tx_valid}, 0);
    check("midrst_data", {mem_addr, tx_data}, 0);
    check("midrst_queues", exp_tx.size() + exp_rd.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    w = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) w++;
    end
    check("midrst_quiet", w, 0);

    // Randomized calls under random back-pressure.
    ready_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       f = 8'd2;
        1, 2, 3: f = 8'd9;
        4:       f = 8'd1;
        default: f = 8'($urandom);
      endcase
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
      len = $urandom_range(0, MAX_LEN + 2);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        if (b == 8'h24) b = 8'h25;
        ram[a + 16'(i)] = b;
      end
      ram[a + 16'(len)] = 8'h24;
      call(f, a, 8'($urandom));
    end
    ready_rand = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
